// File: rtl/accum_bank_slave.sv
// Banked accumulator memory: NUM_BANKS lanes, each written by overwrite or
// modular add, with a one-stage read-modify-write pipeline and 1-cycle reads.

module accum_lane #(
  parameter int DW = 64,
  parameter int IW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic          acc,
  input  logic [IW-1:0] acc_idx,
  input  logic [DW-1:0] acc_data,
  input  logic          fwd,
  input  logic          commit,
  input  logic [IW-1:0] s1_idx,
  input  logic          s1_accum,
  input  logic          rd_acc,
  input  logic [IW-1:0] rd_idx,
  input  logic          rd_en,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**IW];
  logic [DW-1:0] old_q, wd_q, nxt;

  assign nxt = s1_accum ? old_q + wd_q : wd_q;

  // The commit lands in mem at the same edge a new accept samples it, so a
  // same-index follower takes the in-flight sum instead of the stale word.
  always_ff @(posedge clk) begin
    if (clr_en)
      mem[clr_idx] <= '0;
    else if (commit)
      mem[s1_idx] <= nxt;
    if (acc) begin
      old_q <= fwd ? nxt : mem[acc_idx];
      wd_q  <= acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdata <= '0;
    else if (rd_acc)
      rdata <= rd_en ? mem[rd_idx] : '0;
  end
endmodule

module accum_bank_slave #(
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int ZONE_WIDTH = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ZONE_WIDTH-1:0]           wr_zone_id,
  input  logic                            accum_en,
  input  logic [NUM_BANKS-1:0]            wr_mask,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic                            wvalid,
  output logic                            wready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
  input  logic                            rd_valid,
  output logic                            rd_ready,
  input  logic [ZONE_WIDTH-1:0]           rd_zone_id,
  input  logic [NUM_BANKS-1:0]            rd_mask,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic                            rvalid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rdata
);
  localparam int IW = ZONE_WIDTH + ADDR_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t               state;
  logic                 run;
  logic [IW-1:0]        clr_idx;
  logic                 s1_valid, s1_accum;
  logic [IW-1:0]        s1_idx;
  logic [NUM_BANKS-1:0] s1_mask;
  logic [IW-1:0]        wr_idx, rd_idx;
  logic                 wr_acc, rd_acc, s1_hit;

  assign wr_idx   = {wr_zone_id, wr_addr};
  assign rd_idx   = {rd_zone_id, rd_addr};
  assign wr_ready = run;
  assign wready   = run;
  // Stall a read only while S1 still owes one of its lanes to the array.
  assign rd_ready = run & ~(s1_valid & (s1_idx == rd_idx) & (|(s1_mask & rd_mask)));
  assign wr_acc   = wr_valid & wvalid & run;
  assign rd_acc   = rd_valid & rd_ready;
  assign s1_hit   = s1_valid & (s1_idx == wr_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      run      <= 1'b0;
      clr_idx  <= '0;
      s1_valid <= 1'b0;
      rvalid   <= 1'b0;
    end else begin
      s1_valid <= wr_acc;
      rvalid   <= rd_acc;
      if (wr_acc) begin
        s1_idx   <= wr_idx;
        s1_mask  <= wr_mask;
        s1_accum <= accum_en;
      end
      case (state)
        INIT: begin
          clr_idx <= clr_idx + 1'b1;
          if (&clr_idx) begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        RUN: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_lane
    accum_lane #(.DW(DATA_WIDTH), .IW(IW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr_en   (state == INIT),
      .clr_idx  (clr_idx),
      .acc      (wr_acc),
      .acc_idx  (wr_idx),
      .acc_data (wdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .fwd      (s1_hit & s1_mask[i]),
      .commit   (s1_valid & s1_mask[i] & ~rst),
      .s1_idx   (s1_idx),
      .s1_accum (s1_accum),
      .rd_acc   (rd_acc),
      .rd_idx   (rd_idx),
      .rd_en    (rd_mask[i]),
      .rdata    (rdata[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule
